axi4_mem_slave: RTL and testbench



---
 rtl/axi4_mem_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_slave.sv
// rtl/axi4_mem_slave.sv - AXI4 INCR-burst memory responder backed by a word array
// Independent write (AW/W/B) and read (AR/R) FSMs; SLVERR on out-of-range or non-word bursts.
module axi4_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  output logic                  RLAST,
  input  logic                  RREADY
);
  localparam int MW = $clog2(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

  w_state_t              r_wstate, w_wstate_nxt;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [7:0]            r_wlen, r_wcnt;
  logic                  r_wrange_err, r_wlast_err;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;

  r_state_t              r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_ridx;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_rerr;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [ADDR_WIDTH-1:0] w_aw_idx, w_ar_idx, w_ridx_nxt;
  logic                  w_aw_err, w_ar_err, w_aw_hs, w_ar_hs;
  logic                  w_w_beat, w_w_final, w_wlast_bad;
  logic                  w_r_beat, w_r_done;

  // Range check is one bit wider than the address so idx+len cannot wrap.
  assign w_aw_idx    = AWADDR >> 2;
  assign w_aw_err    = (((ADDR_WIDTH+1)'(w_aw_idx) + (ADDR_WIDTH+1)'(AWLEN)) >= DEPTH) || (AWSIZE != 3'd2);
  assign w_aw_hs     = AWVALID && r_awready;
  assign w_w_beat    = WVALID && r_wready;
  assign w_w_final   = w_w_beat && (r_wcnt == r_wlen);
  assign w_wlast_bad = WLAST != (r_wcnt == r_wlen);

  assign w_ar_idx    = ARADDR >> 2;
  assign w_ar_err    = (((ADDR_WIDTH+1)'(w_ar_idx) + (ADDR_WIDTH+1)'(ARLEN)) >= DEPTH) || (ARSIZE != 3'd2);
  assign w_ar_hs     = ARVALID && r_arready;
  assign w_r_beat    = r_rvalid && RREADY;
  assign w_r_done    = w_r_beat && r_rlast;
  assign w_ridx_nxt  = r_ridx + ADDR_WIDTH'(1);

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_final) w_wstate_nxt = W_RESP;
      W_RESP:  if (r_bvalid && BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate     <= W_IDLE;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= 2'b00;
      r_widx       <= '0;
      r_wlen       <= '0;
      r_wcnt       <= '0;
      r_wrange_err <= 1'b0;
      r_wlast_err  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_widx       <= w_aw_idx;
        r_wlen       <= AWLEN;
        r_wcnt       <= '0;
        r_wrange_err <= w_aw_err;
        r_wlast_err  <= 1'b0;
      end
      if (w_w_beat) begin
        r_widx <= r_widx + ADDR_WIDTH'(1);
        r_wcnt <= r_wcnt + 8'd1;
        if (w_wlast_bad) r_wlast_err <= 1'b1;
      end
      if (w_w_final) begin
        r_bresp <= (r_wrange_err || r_wlast_err || w_wlast_bad) ? 2'b10 : 2'b00;
      end else if (r_bvalid && BREADY) begin
        r_bresp <= 2'b00;
      end
    end
  end

  // A WLAST mismatch does not block the write; only an out-of-range burst does.
  always_ff @(posedge ACLK) begin
    if (w_w_beat && !r_wrange_err) r_mem[r_widx[MW-1:0]] <= WDATA;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_done) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rerr    <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_ridx  <= w_ar_idx;
        r_rlen  <= ARLEN;
        r_rcnt  <= '0;
        r_rerr  <= w_ar_err;
        r_rresp <= w_ar_err ? 2'b10 : 2'b00;
        r_rlast <= (ARLEN == 8'd0);
        r_rdata <= w_ar_err ? '0 : r_mem[w_ar_idx[MW-1:0]];
      end else if (w_r_done) begin
        r_rlast <= 1'b0;
        r_rresp <= 2'b00;
      end else if (w_r_beat) begin
        r_ridx  <= w_ridx_nxt;
        r_rcnt  <= r_rcnt + 8'd1;
        r_rlast <= (8'(r_rcnt + 8'd1) == r_rlen);
        r_rdata <= r_rerr ? '0 : r_mem[w_ridx_nxt[MW-1:0]];
      end
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb/tb_axi4_mem_slave.sv - directed plus random bursts against an array model of the memory
module tb_axi4_mem_slave;
  logic        ACLK, ARESETn;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdat [1024];
  bit          mval [1024];
  logic [31:0] wdat [256];

  axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int len, input int size, input int flip);
    int idx, n;
    bit rerr, lerr;
    logic lst;
    idx  = addr >> 2;
    rerr = (idx + len >= 1024) || (size != 2);
    lerr = 1'b0;
    AWADDR = 16'(addr); AWLEN = 8'(len); AWSIZE = 3'(size); AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    chk("awready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(negedge ACLK); end
      lst = (k == len) ^ (k == flip);
      if (lst != (k == len)) lerr = 1'b1;
      WVALID = 1'b1; WDATA = wdat[k]; WLAST = lst;
      n = 0;
      while (WREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
      chk("wready", WREADY, 1);
      @(negedge ACLK);
      if (!rerr) begin mdat[idx+k] = wdat[k]; mval[idx+k] = 1'b1; end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("b_valid", BVALID, 1);
    chk("bresp", BRESP, (rerr || lerr) ? 2 : 0);
    repeat ($urandom_range(0, 2)) @(negedge ACLK);
    chk("b_hold", BVALID, 1);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("b_done", BVALID, 0);
    chk("b_awready", AWREADY, 1);
  endtask

  task automatic rd(input int addr, input int len, input int size, input int mode);
    int idx, n, beat, cyc;
    bit err;
    idx = (addr & 32'hFFFF) >> 2;
    err = (idx + len >= 1024) || (size != 2);
    ARADDR = 16'(addr); ARLEN = 8'(len); ARSIZE = 3'(size); ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    chk("arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("r_first_valid", RVALID, 1);
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 3000) begin
      chk("rvalid", RVALID, 1);
      if (RVALID !== 1'b1) break;
      chk("rresp", RRESP, err ? 2 : 0);
      chk("rlast", RLAST, (beat == len) ? 1 : 0);
      if (err) chk("rdata_err", RDATA, 0);
      else if (mval[idx+beat]) chk("rdata", RDATA, mdat[idx+beat]);
      case (mode)
        0:       RREADY = 1'b1;
        1:       RREADY = cyc[0];
        default: RREADY = 1'($urandom_range(0, 1));
      endcase
      @(negedge ACLK);
      if (RREADY) beat++;
      cyc++;
    end
    RREADY = 1'b0;
    chk("r_end_valid", RVALID, 0);
    chk("r_end_last", RLAST, 0);
    chk("r_end_arready", ARREADY, 1);
  endtask

  initial begin
    int n;
    ARESETn = 1'b0;
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 1024; i++) mval[i] = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    #1 chk("awready_before_edge", AWREADY, 0);
    @(negedge ACLK);
    chk("awready_after_rel", AWREADY, 1);
    chk("arready_after_rel", ARREADY, 1);

    // single beat write/read
    wdat[0] = 32'hDEADBEEF;
    wr('h0010, 0, 2, -1);
    rd('h0010, 0, 2, 0);

    // four-beat burst, read back with RREADY toggling
    for (int k = 0; k < 4; k++) wdat[k] = k + 1;
    wr('h0100, 3, 2, -1);
    rd('h0100, 3, 2, 1);

    // top two words, then out-of-range writes that must not disturb them
    wdat[0] = 32'h11112222; wr('h0FF8, 0, 2, -1);
    wdat[0] = 32'h33334444; wr('h0FFC, 0, 2, -1);
    wdat[0] = 32'hA5A5A5A5;
    wr('hFFF1, 0, 2, -1);
    rd('hFFF1, 0, 2, 0);
    wr(32767, 0, 2, -1);
    rd(32767, 0, 2, 0);
    rd('h0FF8, 1, 2, 0);

    // burst crossing the end of memory
    for (int k = 0; k < 4; k++) wdat[k] = $urandom;
    wr('h0FF8, 3, 2, -1);
    rd('h0FF8, 1, 2, 0);

    // early WLAST: error response, both beats still stored
    wdat[0] = 32'hCAFE0001; wdat[1] = 32'hCAFE0002;
    wr('h0200, 1, 2, 0);
    rd('h0200, 1, 2, 0);

    // unsupported size on both paths
    wdat[0] = 32'h0BADF00D;
    wr('h0300, 0, 1, -1);
    rd('h0300, 0, 1, 0);

    for (int t = 0; t < 24; t++) begin
      int ri, rl, rs, rf;
      ri = int'($urandom_range(0, 1040));
      rl = int'($urandom_range(0, 7));
      rs = ($urandom_range(0, 9) == 0) ? 1 : 2;
      rf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rl)) : -1;
      for (int k = 0; k <= rl; k++) wdat[k] = $urandom;
      wr(ri * 4 + int'($urandom_range(0, 3)), rl, rs, rf);
      rd(ri * 4, rl, 2, 2);
      rd(int'($urandom_range(0, 1040)) * 4, int'($urandom_range(0, 7)), 2, 2);
    end

    // reset while the second beat of a four-beat read is on the bus
    ARADDR = 16'h0100; ARLEN = 8'd3; ARSIZE = 3'd2; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    chk("mid_arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("mid_beat2_data", RDATA, mdat[65]);
    chk("mid_beat2_valid", RVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_rlast", RLAST, 0);
    chk("mid_rst_rdata", RDATA, 0);
    chk("mid_rst_arready", ARREADY, 0);
    RREADY = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_arready", ARREADY, 1);
    chk("post_rst_rvalid", RVALID, 0);
    rd('h0100, 3, 2, 2);
    rd('h0010, 0, 2, 0);
    rd('h0200, 1, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
